vga_field_overlay: RTL and testbench

//  Parametrised text-mode overlay engine for the VGA debug display. Holds a table of N_FIELDS

---
 rtl/vga_field_overlay_if.sv | 16 +
 rtl/vga_field_overlay.sv | 208 ++++++++++++++++++++
 tb/tb_vga_field_overlay.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_field_overlay_if.sv
// Descriptor-table write port of the VGA text overlay: one slot written per cycle when wr is high.
interface vga_field_overlay_if #(
  parameter int N_FIELDS = 16
);
  localparam int IDX_W = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;

  logic             wr;
  logic [IDX_W-1:0] idx;
  logic [4:0]       row;
  logic [6:0]       col;
  logic [1:0]       fmt;
  logic [5:0]       len;

  modport master (output wr, idx, row, col, fmt, len);
  modport slave  (input  wr, idx, row, col, fmt, len);
endinterface

// File: rtl/vga_field_overlay.sv
// Text-mode overlay: renders frame-stable snapshots of datapath values as hex/bin/dec
// characters at programmable text cells, with a 2-cycle lookup from pixel x/y to ASCII.
module vga_field_overlay #(
  parameter int N_FIELDS   = 16,
  parameter int VAL_W      = 32,
  parameter int DEC_DIGITS = 10,
  parameter int COLS       = 80,
  parameter int ROWS       = 30
) (
  input  logic                      clock,
  input  logic                      reset,
  vga_field_overlay_if.slave        cfg,
  input  logic [N_FIELDS*VAL_W-1:0] field_values,
  input  logic                      frame_start,
  input  logic                      freeze,
  input  logic [9:0]                x,
  input  logic [9:0]                y,
  input  logic                      video_on,
  output logic                      char_hit,
  output logic [6:0]                char_out,
  output logic                      busy,
  output logic                      snap_done
);

  localparam int         IDX_W   = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
  localparam int         BCD_W   = 4 * DEC_DIGITS;
  localparam int         CNT_W   = (VAL_W > 1) ? $clog2(VAL_W) : 1;
  localparam logic [7:0] COL_LIM = 8'(COLS);
  localparam logic [5:0] ROW_LIM = 6'(ROWS);

  typedef enum logic [1:0] {FMT_OFF, FMT_HEX, FMT_BIN, FMT_DEC} fmt_e;
  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_SCAN, S_CONV, S_NEXT, S_DONE} state_e;

  logic [4:0] d_row [N_FIELDS];
  logic [6:0] d_col [N_FIELDS];
  fmt_e       d_fmt [N_FIELDS];
  logic [5:0] d_len [N_FIELDS];

  // NOTE: these tables are small register files, so they get a real reset; a RAM-mapped
  // table could not be cleared in one cycle and would need a sweep instead.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_FIELDS; i++) begin
        d_row[i] <= '0;
        d_col[i] <= '0;
        d_fmt[i] <= FMT_OFF;
        d_len[i] <= '0;
      end
    end else if (cfg.wr) begin
      d_row[cfg.idx] <= cfg.row;
      d_col[cfg.idx] <= cfg.col;
      d_fmt[cfg.idx] <= fmt_e'(cfg.fmt);
      d_len[cfg.idx] <= cfg.len;
    end
  end

  // One shift-add-3 step: correct every BCD digit >= 5, then shift in the next binary bit.
  function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] acc, input logic b);
    logic [BCD_W-1:0] a;
    a = acc;
    for (int k = 0; k < DEC_DIGITS; k++)
      if (a[4*k +: 4] >= 4'd5) a[4*k +: 4] = a[4*k +: 4] + 4'd3;
    return {a[BCD_W-2:0], b};
  endfunction

  state_e           state;
  logic [IDX_W-1:0] f;
  logic [VAL_W-1:0] shadow [N_FIELDS];
  logic [BCD_W-1:0] bcd    [N_FIELDS];
  logic [BCD_W-1:0] acc;
  logic [VAL_W-1:0] sreg;
  logic [CNT_W-1:0] cnt;

  // NOTE: every register here uses <= so all updates see the same pre-edge state,
  // whatever order the statements are written in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      f         <= '0;
      busy      <= 1'b0;
      snap_done <= 1'b0;
      acc       <= '0;
      sreg      <= '0;
      cnt       <= '0;
      for (int i = 0; i < N_FIELDS; i++) begin
        shadow[i] <= '0;
        bcd[i]    <= '0;
      end
    end else begin
      snap_done <= 1'b0;
      unique case (state)
        S_IDLE: if (frame_start && !freeze) begin
          state <= S_LATCH;
          busy  <= 1'b1;
        end
        S_LATCH: begin
          for (int i = 0; i < N_FIELDS; i++) shadow[i] <= field_values[i*VAL_W +: VAL_W];
          f     <= '0;
          state <= S_SCAN;
        end
        S_SCAN: if (d_fmt[f] == FMT_DEC && d_len[f] != 6'd0) begin
          sreg  <= shadow[f];
          acc   <= '0;
          cnt   <= '0;
          state <= S_CONV;
        end else begin
          state <= S_NEXT;
        end
        S_CONV: begin
          acc  <= dabble(acc, sreg[VAL_W-1]);
          sreg <= {sreg[VAL_W-2:0], 1'b0};
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(VAL_W - 1)) begin
            bcd[f] <= dabble(acc, sreg[VAL_W-1]);
            state  <= S_NEXT;
          end
        end
        S_NEXT: if (f == IDX_W'(N_FIELDS - 1)) begin
          state     <= S_DONE;
          snap_done <= 1'b1;
        end else begin
          f     <= f + 1'b1;
          state <= S_SCAN;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [6:0] cell_c;
  logic [4:0] cell_r;
  logic       unused_bits;
  assign cell_c      = x[9:3];
  assign cell_r      = y[8:4];
  assign unused_bits = ^{x[2:0], y[9], y[3:0]};

  logic             hit_n;
  logic [IDX_W-1:0] idx_n;
  logic [5:0]       digit_n;
  fmt_e             fmt_n;

  // Scan from the top so the lowest matching index is written last and wins.
  // NOTE: all outputs are defaulted first so no path through the loop leaves a latch.
  always_comb begin
    hit_n   = 1'b0;
    idx_n   = '0;
    digit_n = '0;
    fmt_n   = FMT_OFF;
    for (int i = N_FIELDS - 1; i >= 0; i--) begin
      if (d_fmt[i] != FMT_OFF && d_len[i] != 6'd0 && d_row[i] == cell_r &&
          cell_c >= d_col[i] &&
          {1'b0, cell_c} < ({1'b0, d_col[i]} + {2'b00, d_len[i]}) &&
          {1'b0, cell_c} < COL_LIM && {1'b0, cell_r} < ROW_LIM) begin
        hit_n   = 1'b1;
        idx_n   = IDX_W'(i);
        digit_n = 6'({1'b0, d_len[i]} - 7'd1 - (cell_c - d_col[i]));
        fmt_n   = d_fmt[i];
      end
    end
  end

  logic             s1_hit;
  logic             s1_video;
  logic [IDX_W-1:0] s1_idx;
  logic [5:0]       s1_digit;
  fmt_e             s1_fmt;
  logic [3:0]       nib;

  // Digit indices past the stored width shift everything out and read as 0.
  always_comb begin
    nib = 4'h0;
    unique case (s1_fmt)
      FMT_HEX: nib = 4'(shadow[s1_idx] >> {s1_digit, 2'b00});
      FMT_BIN: nib = 4'(shadow[s1_idx] >> s1_digit) & 4'h1;
      FMT_DEC: nib = 4'(bcd[s1_idx] >> {s1_digit, 2'b00});
      default: nib = 4'h0;
    endcase
  end

  function automatic logic [6:0] to_ascii(input logic [3:0] v);
    return (v < 4'd10) ? 7'h30 + {3'b000, v} : 7'h37 + {3'b000, v};
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_hit   <= 1'b0;
      s1_video <= 1'b0;
      s1_idx   <= '0;
      s1_digit <= '0;
      s1_fmt   <= FMT_OFF;
      char_hit <= 1'b0;
      char_out <= 7'h00;
    end else begin
      s1_hit   <= hit_n;
      s1_video <= video_on;
      s1_idx   <= idx_n;
      s1_digit <= digit_n;
      s1_fmt   <= fmt_n;
      char_hit <= s1_hit & s1_video;
      char_out <= s1_hit ? to_ascii(nib) : 7'h00;
    end
  end

endmodule

// File: tb/tb_vga_field_overlay.sv
// Directed bench for vga_field_overlay: cell lookup table plus snapshot, freeze, overlap
// and asynchronous-reset sequences.
module tb_vga_field_overlay;
  localparam int N = 16;
  localparam int W = 32;
  localparam logic [1:0] F_OFF = 2'd0, F_HEX = 2'd1, F_BIN = 2'd2, F_DEC = 2'd3;
  // LATCH + (SCAN,NEXT) per field + 32 CONV cycles per dec field + DONE
  localparam int BUSY_TWO_DEC = 1 + 2*N + 2*W + 1;

  logic               clock = 1'b0;
  logic               reset;
  logic [N*W-1:0]     field_values;
  logic               frame_start, freeze, video_on;
  logic [9:0]         x, y;
  logic               char_hit, busy, snap_done;
  logic [6:0]         char_out;

  always #5 clock = ~clock;

  vga_field_overlay_if #(.N_FIELDS(N)) cfg_if ();

  vga_field_overlay #(.N_FIELDS(N), .VAL_W(W), .DEC_DIGITS(10), .COLS(80), .ROWS(30)) dut (
    .clock(clock), .reset(reset), .cfg(cfg_if), .field_values(field_values),
    .frame_start(frame_start), .freeze(freeze), .x(x), .y(y), .video_on(video_on),
    .char_hit(char_hit), .char_out(char_out), .busy(busy), .snap_done(snap_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input int i, input int row, input int col, input logic [1:0] fmt,
                           input int len);
    @(negedge clock);
    cfg_if.wr  = 1'b1;
    cfg_if.idx = 4'(i);
    cfg_if.row = 5'(row);
    cfg_if.col = 7'(col);
    cfg_if.fmt = fmt;
    cfg_if.len = 6'(len);
    @(negedge clock);
    cfg_if.wr  = 1'b0;
  endtask

  task automatic set_value(input int i, input logic [31:0] v);
    field_values[i*W +: W] = v;
  endtask

  task automatic read_cell(input int c, input int r, input logic vid,
                           output logic h, output logic [6:0] ch);
    @(negedge clock);
    x        = 10'(c * 8);
    y        = 10'(r * 16);
    video_on = vid;
    @(posedge clock);
    @(posedge clock);
    #1;
    h  = char_hit;
    ch = char_out;
  endtask

  task automatic expect_cell(input int c, input int r, input logic hit, input logic [6:0] ch,
                             input string name);
    logic       h;
    logic [6:0] a;
    read_cell(c, r, 1'b1, h, a);
    check({name, "_hit"}, 32'(h), 32'(hit));
    check({name, "_char"}, 32'(a), 32'(ch));
  endtask

  // Fixed 200-cycle window, so a stuck FSM shows up as a wrong count rather than a hang.
  task automatic run_snapshot(input bit second_pulse, output int busy_cyc, output int dones);
    busy_cyc = 0;
    dones    = 0;
    @(negedge clock);
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (busy) busy_cyc++;
      if (snap_done) dones++;
      frame_start = (second_pulse && k == 20);
      @(negedge clock);
    end
    frame_start = 1'b0;
  endtask

  typedef struct {
    int         c;
    int         r;
    logic       vid;
    logic       hit;
    logic       chk;
    logic [6:0] ch;
    string      name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int         bc, dn;
    logic       h;
    logic [6:0] a;

    reset        = 1'b1;
    cfg_if.wr    = 1'b0;
    cfg_if.idx   = '0;
    cfg_if.row   = '0;
    cfg_if.col   = '0;
    cfg_if.fmt   = '0;
    cfg_if.len   = '0;
    field_values = '0;
    frame_start  = 1'b0;
    freeze       = 1'b0;
    x            = '0;
    y            = '0;
    video_on     = 1'b0;
    #12;
    @(negedge clock);
    reset = 1'b0;

    check("rst_char_hit", 32'(char_hit), 32'd0);
    check("rst_char_out", 32'(char_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_snap_done", 32'(snap_done), 32'd0);
    expect_cell(11, 3, 1'b0, 7'h00, "rst_no_fields");

    cfg_write(0, 3, 11, F_HEX, 8);   set_value(0, 32'hDEADBEEF);
    cfg_write(1, 8, 30, F_BIN, 7);   set_value(1, 32'h0000_0033);
    cfg_write(2, 5, 20, F_DEC, 10);  set_value(2, 32'hFFFF_FFFF);
    cfg_write(3, 6, 0, F_DEC, 3);    set_value(3, 32'd7);
    cfg_write(4, 10, 78, F_HEX, 4);  set_value(4, 32'h0000_1234);
    cfg_write(5, 12, 5, F_HEX, 0);   set_value(5, 32'h0000_00FF);
    cfg_write(6, 14, 0, F_HEX, 10);  set_value(6, 32'hABCD_EF01);

    run_snapshot(1'b0, bc, dn);
    check("snap_busy_cycles", 32'(bc), 32'(BUSY_TWO_DEC));
    check("snap_done_count", 32'(dn), 32'd1);

    vecs.push_back('{11, 3, 1'b1, 1'b1, 1'b1, 7'h44, "hex_d7"});
    vecs.push_back('{12, 3, 1'b1, 1'b1, 1'b1, 7'h45, "hex_d6"});
    vecs.push_back('{14, 3, 1'b1, 1'b1, 1'b1, 7'h44, "hex_d4"});
    vecs.push_back('{18, 3, 1'b1, 1'b1, 1'b1, 7'h46, "hex_d0"});
    vecs.push_back('{10, 3, 1'b1, 1'b0, 1'b1, 7'h00, "hex_left_miss"});
    vecs.push_back('{19, 3, 1'b1, 1'b0, 1'b1, 7'h00, "hex_right_miss"});
    vecs.push_back('{11, 4, 1'b1, 1'b0, 1'b1, 7'h00, "row_miss"});
    vecs.push_back('{20, 5, 1'b1, 1'b1, 1'b1, 7'h34, "dec_msd"});
    vecs.push_back('{21, 5, 1'b1, 1'b1, 1'b1, 7'h32, "dec_d8"});
    vecs.push_back('{25, 5, 1'b1, 1'b1, 1'b1, 7'h36, "dec_d4"});
    vecs.push_back('{29, 5, 1'b1, 1'b1, 1'b1, 7'h35, "dec_lsd"});
    vecs.push_back('{0, 6, 1'b1, 1'b1, 1'b1, 7'h30, "dec7_d2"});
    vecs.push_back('{1, 6, 1'b1, 1'b1, 1'b1, 7'h30, "dec7_d1"});
    vecs.push_back('{2, 6, 1'b1, 1'b1, 1'b1, 7'h37, "dec7_d0"});
    vecs.push_back('{30, 8, 1'b1, 1'b1, 1'b1, 7'h30, "bin_d6"});
    vecs.push_back('{31, 8, 1'b1, 1'b1, 1'b1, 7'h31, "bin_d5"});
    vecs.push_back('{33, 8, 1'b1, 1'b1, 1'b1, 7'h30, "bin_d3"});
    vecs.push_back('{36, 8, 1'b1, 1'b1, 1'b1, 7'h31, "bin_d0"});
    vecs.push_back('{77, 10, 1'b1, 1'b0, 1'b1, 7'h00, "clip_left_miss"});
    vecs.push_back('{78, 10, 1'b1, 1'b1, 1'b1, 7'h31, "clip_col78"});
    vecs.push_back('{79, 10, 1'b1, 1'b1, 1'b1, 7'h32, "clip_col79"});
    vecs.push_back('{80, 10, 1'b1, 1'b0, 1'b1, 7'h00, "clip_col80"});
    vecs.push_back('{5, 12, 1'b1, 1'b0, 1'b1, 7'h00, "len0_miss"});
    vecs.push_back('{0, 14, 1'b1, 1'b1, 1'b1, 7'h30, "hex_beyond_d9"});
    vecs.push_back('{1, 14, 1'b1, 1'b1, 1'b1, 7'h30, "hex_beyond_d8"});
    vecs.push_back('{2, 14, 1'b1, 1'b1, 1'b1, 7'h41, "hex_d7_A"});
    vecs.push_back('{11, 3, 1'b0, 1'b0, 1'b0, 7'h00, "video_off"});

    foreach (vecs[i]) begin
      read_cell(vecs[i].c, vecs[i].r, vecs[i].vid, h, a);
      check({vecs[i].name, "_hit"}, 32'(h), 32'(vecs[i].hit));
      if (vecs[i].chk) check({vecs[i].name, "_char"}, 32'(a), 32'(vecs[i].ch));
    end

    // Switching to dec between snapshots shows the never-converted BCD (zero).
    cfg_write(0, 3, 11, F_DEC, 8);
    expect_cell(18, 3, 1'b1, 7'h30, "dec_switch_old_bcd");
    cfg_write(0, 3, 11, F_HEX, 8);

    // Field 0 over the bin cells wins; disabling it reveals field 1.
    cfg_write(0, 8, 30, F_HEX, 8);
    expect_cell(30, 8, 1'b1, 7'h44, "overlap_f0_d7");
    expect_cell(36, 8, 1'b1, 7'h45, "overlap_f0_d1");
    cfg_write(0, 8, 30, F_OFF, 8);
    expect_cell(30, 8, 1'b1, 7'h30, "overlap_off_d6");
    expect_cell(31, 8, 1'b1, 7'h31, "overlap_off_d5");
    cfg_write(0, 3, 11, F_HEX, 8);

    freeze = 1'b1;
    set_value(0, 32'h1234_5678);
    run_snapshot(1'b0, bc, dn);
    check("freeze_busy_cycles", 32'(bc), 32'd0);
    check("freeze_done_count", 32'(dn), 32'd0);
    expect_cell(11, 3, 1'b1, 7'h44, "freeze_old_digit");
    freeze = 1'b0;
    run_snapshot(1'b1, bc, dn);
    check("repulse_busy_cycles", 32'(bc), 32'(BUSY_TWO_DEC));
    check("repulse_done_count", 32'(dn), 32'd1);
    expect_cell(11, 3, 1'b1, 7'h31, "new_snap_d7");
    expect_cell(18, 3, 1'b1, 7'h38, "new_snap_d0");

    // Reset in the 10th CONV cycle of field 2 (busy cycle 16).
    @(negedge clock);
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    repeat (15) @(negedge clock);
    check("midconv_busy", 32'(busy), 32'd1);
    check("midconv_char_hit", 32'(char_hit), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_char_hit", 32'(char_hit), 32'd0);
    check("async_rst_char_out", 32'(char_out), 32'd0);
    check("async_rst_snap_done", 32'(snap_done), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    expect_cell(11, 3, 1'b0, 7'h00, "post_rst_desc_off");
    expect_cell(29, 5, 1'b0, 7'h00, "post_rst_dec_off");
    cfg_write(2, 5, 20, F_DEC, 10);
    expect_cell(29, 5, 1'b1, 7'h30, "post_rst_bcd_clear");
    cfg_write(0, 3, 11, F_HEX, 8);
    expect_cell(11, 3, 1'b1, 7'h30, "post_rst_shadow_clear");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
